// File: rtl/user_code_pkg.sv
// -----------------------------------------------------------------------------
// user_code_pkg
// Shared types and constants for the user code memory slice.
//   state_e        : loader FSM states (IDLE, LOAD)
//   DEFAULT_WIDTH  : default instruction word width in bits
//   DEFAULT_DEPTH  : default number of instruction words
//   NOP            : all-zero instruction word; slice [WIDTH-1:0] for use
// -----------------------------------------------------------------------------
package user_code_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 16;

    // Wide enough for any practical WIDTH; users take the low WIDTH bits.
    localparam int NOP_MAX_W = 1024;
    localparam logic [NOP_MAX_W-1:0] NOP = '0;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_e;

endpackage

// File: rtl/user_code_loader.sv
// -----------------------------------------------------------------------------
// user_code_loader
// Load-session controller for the user code memory: FSM, write pointer,
// word counter and (optionally) the running checksum of accepted words.
//
// Ports
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   ld_start_i        : begin a session (honoured in IDLE only)
//   ld_valid_i        : loader word present
//   ld_data_i         : loader word
//   ld_last_i         : final word of the session
//   ld_ready_o        : word accepted this cycle when ld_valid_i is high
//   busy_o            : session in progress
//   ld_done_o         : one-cycle pulse after the session's final word
//   ld_count_o        : words written by the last or current session
//   clear_o           : wipe all storage words on this edge
//   wr_en_o           : write wr_data_o to word wr_addr_o on this edge
//   wr_addr_o         : write pointer
//   wr_data_o         : word being written
//   ld_checksum_o     : modulo-2^WIDTH sum of accepted words
//                       (present only with USER_CODE_CHECKSUM_EN defined)
//
// States
//   IDLE | no session; fetches served, loader stream ignored
//   LOAD | session open; words written at wptr until last word or top address
// -----------------------------------------------------------------------------
module user_code_loader
    import user_code_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ld_start_i,
    input  logic             ld_valid_i,
    input  logic [WIDTH-1:0] ld_data_i,
    input  logic             ld_last_i,
    output logic             ld_ready_o,
    output logic             busy_o,
    output logic             ld_done_o,
    output logic [AW:0]      ld_count_o,
    output logic             clear_o,
    output logic             wr_en_o,
    output logic [AW-1:0]    wr_addr_o,
    output logic [WIDTH-1:0] wr_data_o
`ifdef USER_CODE_CHECKSUM_EN
    ,
    output logic [WIDTH-1:0] ld_checksum_o
`endif
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_e          state_q;
    logic            busy_q;
    logic            done_q;
    logic [AW-1:0]   wptr_q;
    logic [AW:0]     count_q;
`ifdef USER_CODE_CHECKSUM_EN
    logic [WIDTH-1:0] csum_q;
`endif

    logic start_d;
    logic accept_d;
    logic end_d;

    // busy_q mirrors (state_q == LOAD) so ready/busy come straight off a flop.
    assign start_d  = (state_q == IDLE) && ld_start_i;
    assign accept_d = busy_q && ld_valid_i;
    assign end_d    = accept_d && (ld_last_i || (wptr_q == LAST_ADDR));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wptr_q  <= '0;
            count_q <= '0;
`ifdef USER_CODE_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_d) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                        wptr_q  <= '0;
                        count_q <= '0;
`ifdef USER_CODE_CHECKSUM_EN
                        csum_q  <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (accept_d) begin
                        wptr_q  <= wptr_q + 1'b1;
                        count_q <= count_q + 1'b1;
`ifdef USER_CODE_CHECKSUM_EN
                        csum_q  <= csum_q + ld_data_i;
`endif
                        if (end_d) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ld_ready_o = busy_q;
    assign busy_o     = busy_q;
    assign ld_done_o  = done_q;
    assign ld_count_o = count_q;
    assign clear_o    = start_d;
    assign wr_en_o    = accept_d;
    assign wr_addr_o  = wptr_q;
    assign wr_data_o  = ld_data_i;
`ifdef USER_CODE_CHECKSUM_EN
    assign ld_checksum_o = csum_q;
`endif

endmodule

// File: rtl/user_code_memory.sv
// -----------------------------------------------------------------------------
// user_code_memory
// Small instruction store: written by a streaming loader session, read by a
// single-cycle-latency fetch port. Storage and fetch path live here; the
// session control lives in user_code_loader.
//
// Ports
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   fetch_en_i        : fetch request, sampled each cycle
//   fetch_addr_i      : word address of the fetch
//   instr_out_o       : fetched word (holds while instr_valid_o is low)
//   instr_valid_o     : one-cycle pulse qualifying instr_out_o
//   addr_err_o        : with instr_valid_o, fetch address was >= DEPTH
//   ld_start_i        : begin a load session
//   ld_valid_i, ld_data_i, ld_last_i : loader word stream
//   ld_ready_o        : loader word accepted this cycle
//   busy_o            : load session in progress
//   ld_done_o         : one-cycle pulse after a session ends
//   ld_count_o        : words written by the last or current session
//   ld_checksum_o     : sum of accepted words, present only when the
//                       USER_CODE_CHECKSUM_EN macro is defined
// -----------------------------------------------------------------------------
module user_code_memory
    import user_code_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             fetch_en_i,
    input  logic [AW-1:0]    fetch_addr_i,
    output logic [WIDTH-1:0] instr_out_o,
    output logic             instr_valid_o,
    output logic             addr_err_o,
    input  logic             ld_start_i,
    input  logic             ld_valid_i,
    input  logic [WIDTH-1:0] ld_data_i,
    input  logic             ld_last_i,
    output logic             ld_ready_o,
    output logic             busy_o,
    output logic             ld_done_o,
    output logic [AW:0]      ld_count_o
`ifdef USER_CODE_CHECKSUM_EN
    ,
    output logic [WIDTH-1:0] ld_checksum_o
`endif
);

    localparam logic [WIDTH-1:0] NOP_WORD = NOP[WIDTH-1:0];

    logic             busy;
    logic             clear;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] instr_q, instr_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             fetch_ok;
    logic             in_range;

    user_code_loader #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_loader (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .ld_start_i (ld_start_i),
        .ld_valid_i (ld_valid_i),
        .ld_data_i  (ld_data_i),
        .ld_last_i  (ld_last_i),
        .ld_ready_o (ld_ready_o),
        .busy_o     (busy),
        .ld_done_o  (ld_done_o),
        .ld_count_o (ld_count_o),
        .clear_o    (clear),
        .wr_en_o    (wr_en),
        .wr_addr_o  (wr_addr),
        .wr_data_o  (wr_data)
`ifdef USER_CODE_CHECKSUM_EN
        ,
        .ld_checksum_o (ld_checksum_o)
`endif
    );

    assign busy_o = busy;

    // Session start wipes every word to NOP on the same edge it enters LOAD.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= NOP_WORD;
            end
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= NOP_WORD;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // A starting session takes precedence over a fetch in the same cycle.
    assign fetch_ok = fetch_en_i && !busy && !ld_start_i;
    // Extra bit so non-power-of-two DEPTH can flag the unused top addresses.
    assign in_range = ({1'b0, fetch_addr_i} < (AW + 1)'(DEPTH));

    always_comb begin
        instr_d = instr_q;
        valid_d = fetch_ok;
        err_d   = 1'b0;
        if (fetch_ok) begin
            if (in_range) begin
                instr_d = mem_q[fetch_addr_i];
            end else begin
                instr_d = NOP_WORD;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            instr_q <= instr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign instr_out_o   = instr_q;
    assign instr_valid_o = valid_q;
    assign addr_err_o    = err_q;

endmodule

// File: tb/tb_user_code_memory.sv
`timescale 1ns/1ps
module tb_user_code_memory;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_chk;
    int   n_fail;

    exp_t q16[$];
    exp_t q12[$];
    chk_t chk_q[$];

    // DEPTH = 16 instance
    logic        f_en, ls, lv, ll;
    logic [3:0]  f_addr;
    logic [15:0] ld, i_out;
    logic        i_val, a_err, lr, bz, dn;
    logic [4:0]  lc;
`ifdef USER_CODE_CHECKSUM_EN
    logic [15:0] cs;
    logic [15:0] cs12;
`endif

    // DEPTH = 12 instance
    logic        f_en12, ls12, lv12, ll12;
    logic [3:0]  f_addr12;
    logic [15:0] ld12, i_out12;
    logic        i_val12, a_err12, lr12, bz12, dn12;
    logic [4:0]  lc12;

    user_code_memory #(.WIDTH(16), .DEPTH(16)) u_dut (
        .clk_i (clk), .rst_i (rst),
        .fetch_en_i (f_en), .fetch_addr_i (f_addr),
        .instr_out_o (i_out), .instr_valid_o (i_val), .addr_err_o (a_err),
        .ld_start_i (ls), .ld_valid_i (lv), .ld_data_i (ld), .ld_last_i (ll),
        .ld_ready_o (lr), .busy_o (bz), .ld_done_o (dn), .ld_count_o (lc)
`ifdef USER_CODE_CHECKSUM_EN
        , .ld_checksum_o (cs)
`endif
    );

    user_code_memory #(.WIDTH(16), .DEPTH(12)) u_dut12 (
        .clk_i (clk), .rst_i (rst),
        .fetch_en_i (f_en12), .fetch_addr_i (f_addr12),
        .instr_out_o (i_out12), .instr_valid_o (i_val12), .addr_err_o (a_err12),
        .ld_start_i (ls12), .ld_valid_i (lv12), .ld_data_i (ld12), .ld_last_i (ll12),
        .ld_ready_o (lr12), .busy_o (bz12), .ld_done_o (dn12), .ld_count_o (lc12)
`ifdef USER_CODE_CHECKSUM_EN
        , .ld_checksum_o (cs12)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    // Monitor / scoreboard: sole owner of the comparison counters.
    initial begin
        chk_t c;
        exp_t e;
        n_chk  = 0;
        n_fail = 0;
        forever begin
            @(negedge clk);
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                n_chk++;
                if (c.act !== c.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %0h, expected %0h", c.name, c.act, c.exp);
                end
            end
            if (!rst && i_val === 1'b1) begin
                n_chk++;
                if (q16.size() == 0) begin
                    n_fail++;
                    $display("FAIL fetch16_unexpected: instr_valid at cycle %0d with data %h, expected none", cyc, i_out);
                end else begin
                    e = q16.pop_front();
                    if (i_out !== e.data || a_err !== e.err || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL fetch16: got data=%h err=%b cyc=%0d, expected data=%h err=%b cyc=%0d",
                                 i_out, a_err, cyc, e.data, e.err, e.cyc);
                    end
                end
            end
            if (!rst && i_val12 === 1'b1) begin
                n_chk++;
                if (q12.size() == 0) begin
                    n_fail++;
                    $display("FAIL fetch12_unexpected: instr_valid at cycle %0d with data %h, expected none", cyc, i_out12);
                end else begin
                    e = q12.pop_front();
                    if (i_out12 !== e.data || a_err12 !== e.err || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL fetch12: got data=%h err=%b cyc=%0d, expected data=%h err=%b cyc=%0d",
                                 i_out12, a_err12, cyc, e.data, e.err, e.cyc);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic fetch16(input logic [3:0] a, input logic [15:0] d, input logic e);
        exp_t x;
        x.data = d;
        x.err  = e;
        x.cyc  = cyc + 1;
        f_en   = 1'b1;
        f_addr = a;
        q16.push_back(x);
        tick();
        f_en   = 1'b0;
    endtask

    task automatic fetch12(input logic [3:0] a, input logic [15:0] d, input logic e);
        exp_t x;
        x.data   = d;
        x.err    = e;
        x.cyc    = cyc + 1;
        f_en12   = 1'b1;
        f_addr12 = a;
        q12.push_back(x);
        tick();
        f_en12   = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        rst = 1'b1;
        f_en = 0; f_addr = 0; ls = 0; lv = 0; ll = 0; ld = 0;
        f_en12 = 0; f_addr12 = 0; ls12 = 0; lv12 = 0; ll12 = 0; ld12 = 0;
        tick();
        tick();

        // Reset state
        chk("rst_instr_out", 32'(i_out), 32'h0);
        chk("rst_instr_valid", 32'(i_val), 32'h0);
        chk("rst_addr_err", 32'(a_err), 32'h0);
        chk("rst_busy", 32'(bz), 32'h0);
        chk("rst_ld_ready", 32'(lr), 32'h0);
        chk("rst_ld_done", 32'(dn), 32'h0);
        chk("rst_ld_count", 32'(lc), 32'h0);
`ifdef USER_CODE_CHECKSUM_EN
        chk("rst_checksum", 32'(cs), 32'h0);
`endif
        rst = 1'b0;
        tick();

        // Fresh memory reads back all zeros, one result per cycle
        for (int a = 0; a < 16; a++) fetch16(4'(a), 16'h0000, 1'b0);
        tick();

        // Three-word session ended by ld_last
        busy_cnt = 0;
        ls = 1'b1;
        tick();
        ls = 1'b0;
        chk("s1_ready_at_start", 32'(lr), 32'h1);
        chk("s1_count_at_start", 32'(lc), 32'h0);
        busy_cnt += int'(bz);
        lv = 1'b1; ld = 16'h5401;
        tick();
        busy_cnt += int'(bz);
        chk("s1_count_w1", 32'(lc), 32'h1);
        ld = 16'hE0F6;
        tick();
        busy_cnt += int'(bz);
        ld = 16'h8005; ll = 1'b1;
        tick();
        busy_cnt += int'(bz);
        lv = 1'b0; ll = 1'b0;
        chk("s1_busy_cycles", 32'(busy_cnt), 32'd3);
        chk("s1_ld_done", 32'(dn), 32'h1);
        chk("s1_ld_count", 32'(lc), 32'd3);
        // Loader words in IDLE are ignored
        lv = 1'b1; ld = 16'h1234;
        tick();
        lv = 1'b0;
        chk("s1_done_one_cycle", 32'(dn), 32'h0);
        chk("s1_idle_valid_ignored", 32'(lc), 32'd3);
        fetch16(4'd1, 16'hE0F6, 1'b0);
        fetch16(4'd3, 16'h0000, 1'b0);
        fetch16(4'd0, 16'h5401, 1'b0);
        fetch16(4'd2, 16'h8005, 1'b0);
        tick();
        chk("hold_instr_out", 32'(i_out), 32'h8005);
        chk("hold_instr_valid", 32'(i_val), 32'h0);

        // Seventeen words, no ld_last: session closes at the top address
        ls = 1'b1; f_en = 1'b1; f_addr = 4'd0;
        tick();
        ls = 1'b0; f_en = 1'b0;
        for (int i = 0; i < 17; i++) begin
            lv = 1'b1;
            ld = 16'h1000 + 16'(i);
            ls = (i == 4);
            f_en = (i == 2);
            f_addr = 4'd5;
            chk($sformatf("s2_ready_w%0d", i), 32'(lr), 32'(i < 16));
            tick();
            if (i == 15) begin
                chk("s2_done_after_w16", 32'(dn), 32'h1);
                chk("s2_busy_after_w16", 32'(bz), 32'h0);
            end
        end
        lv = 1'b0; ls = 1'b0; f_en = 1'b0;
        chk("s2_ld_count", 32'(lc), 32'd16);
        tick();
        fetch16(4'd15, 16'h100F, 1'b0);
        fetch16(4'd0, 16'h1000, 1'b0);
        fetch16(4'd4, 16'h1004, 1'b0);
        tick();

        // Reset in the middle of a session
        ls = 1'b1;
        tick();
        ls = 1'b0;
        lv = 1'b1; ld = 16'hA001;
        tick();
        ld = 16'hA002;
        tick();
        chk("s3_count_before_rst", 32'(lc), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("s3_rst_busy", 32'(bz), 32'h0);
        chk("s3_rst_count", 32'(lc), 32'h0);
        rst = 1'b0;
        for (int i = 3; i <= 5; i++) begin
            ld = 16'hA000 + 16'(i);
            tick();
            chk($sformatf("s3_no_done_%0d", i), 32'(dn), 32'h0);
            chk($sformatf("s3_idle_%0d", i), 32'(bz), 32'h0);
        end
        lv = 1'b0;
        tick();
        chk("s3_no_done_end", 32'(dn), 32'h0);
        fetch16(4'd0, 16'h0000, 1'b0);
        fetch16(4'd1, 16'h0000, 1'b0);
        fetch16(4'd15, 16'h0000, 1'b0);
        tick();

`ifdef USER_CODE_CHECKSUM_EN
        // Checksum wraps modulo 2^16 and holds after the session
        ls = 1'b1;
        tick();
        ls = 1'b0;
        chk("cs_cleared_at_start", 32'(cs), 32'h0);
        lv = 1'b1; ld = 16'hFFFF;
        tick();
        ld = 16'h0002; ll = 1'b1;
        tick();
        lv = 1'b0; ll = 1'b0;
        chk("cs_done", 32'(dn), 32'h1);
        chk("cs_value", 32'(cs), 32'h0001);
        tick();
        tick();
        chk("cs_stable", 32'(cs), 32'h0001);
`endif

        // DEPTH = 12: out-of-range fetches and fetch during LOAD
        fetch12(4'd13, 16'h0000, 1'b1);
        fetch12(4'd11, 16'h0000, 1'b0);
        tick();
        ls12 = 1'b1;
        tick();
        ls12 = 1'b0;
        lv12 = 1'b1; ld12 = 16'hBEEF;
        f_en12 = 1'b1; f_addr12 = 4'd0;
        tick();
        f_en12 = 1'b0;
        ld12 = 16'h0A0A; ll12 = 1'b1;
        tick();
        lv12 = 1'b0; ll12 = 1'b0;
        chk("d12_done", 32'(dn12), 32'h1);
        chk("d12_count", 32'(lc12), 32'd2);
        fetch12(4'd1, 16'h0A0A, 1'b0);
        fetch12(4'd0, 16'hBEEF, 1'b0);
        fetch12(4'd13, 16'h0000, 1'b1);
        fetch12(4'd15, 16'h0000, 1'b1);
        tick();
        chk("d12_err_pulse_only", 32'(a_err12), 32'h0);

        tick();
        tick();
        tick();
        chk("sb16_drained", 32'(q16.size()), 32'h0);
        chk("sb12_drained", 32'(q12.size()), 32'h0);
        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/user_code_memory.md
USER_CODE_MEMORY -- requirements
Module: user_code_memory

Interface
REQ-001 The block SHALL take parameter WIDTH, default 16, as the instruction word width in bits.
REQ-002 The block SHALL take parameter DEPTH, default 16, as the number of instruction words (range 2..256).
REQ-003 The block SHALL derive localparam AW = clog2(DEPTH), the address width.
REQ-004 Clock  input  1  single clock; all state updates on its rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 fetch_en  input  1  fetch request, sampled each cycle.
REQ-007 fetch_addr  input  AW  word address of the fetch.
REQ-008 instr_out  output  WIDTH  fetched instruction word.
REQ-009 instr_valid  output  1  one-cycle pulse qualifying instr_out.
REQ-010 addr_err  output  1  pulse with instr_valid when fetch_addr >= DEPTH.
REQ-011 ld_start  input  1  begins a load session.
REQ-012 ld_valid / ld_data[WIDTH] / ld_last  input  loader word stream; ld_last marks the final word.
REQ-013 ld_ready  output  1  block accepts a loader word this cycle.
REQ-014 busy  output  1  load session in progress.
REQ-015 ld_done  output  1  one-cycle pulse at the end of a session.
REQ-016 ld_count  output  AW+1  number of words written by the last or current session.

Function
REQ-017 The FSM SHALL have states IDLE and LOAD; busy = (state == LOAD); ld_ready = busy.
REQ-018 IDLE with ld_start: next state LOAD, every word cleared to 0 (NOP) in the same edge, write pointer and ld_count set to 0.
REQ-019 LOAD: each cycle with ld_valid && ld_ready writes ld_data to word[wptr], increments wptr and ld_count.
REQ-020 LOAD SHALL exit to IDLE, with ld_done pulsing on the following cycle, when the accepted word has ld_last=1 or is written at address DEPTH-1, whichever comes first.
REQ-021 ld_start during LOAD SHALL be ignored; ld_valid during IDLE SHALL be ignored.
REQ-022 Fetch in IDLE: fetch_en at edge N gives instr_out = word[fetch_addr] and instr_valid=1 after edge N+1 (1-cycle latency), for one cycle per request; back-to-back fetches give one result per cycle.
REQ-023 Out-of-range fetch_addr SHALL return instr_out=0, instr_valid=1, addr_err=1.
REQ-024 fetch_en during LOAD, or coinciding with ld_start in IDLE, SHALL be dropped (instr_valid stays 0); ld_start has priority.
REQ-025 instr_out SHALL hold its last value while instr_valid=0.

Reset
REQ-026 Reset SHALL force state=IDLE, all words=0, instr_out=0, instr_valid=0, addr_err=0, ld_done=0, ld_count=0, wptr=0, immediately and independent of Clock.
REQ-027 Reset asserted mid-LOAD SHALL abandon the session, with no ld_done pulse.

Configuration
REQ-028 With USER_CODE_CHECKSUM_EN defined, the block SHALL add output ld_checksum[WIDTH]: cleared on session start, accumulating the modulo-2^WIDTH sum of every accepted word, stable from ld_done until the next ld_start, and reset to 0.
REQ-029 Without USER_CODE_CHECKSUM_EN, the port and its adder SHALL be absent; all other behaviour is unchanged.

Structure
REQ-030 Package user_code_pkg SHALL hold the state enum (IDLE, LOAD), the NOP constant (all zeros) and the default WIDTH/DEPTH values.
REQ-031 The FSM, write pointer, ld_count and checksum SHALL live in sub-module user_code_loader; the storage array and fetch path SHALL live in the top.

Verification
REQ-032 Reset, then fetch addresses 0..15 -> sixteen results of 16'h0000, instr_valid high one cycle after each request.
REQ-033 ld_start, then words 16'h5401, 16'hE0F6, 16'h8005 with ld_last on the third -> busy for 3 cycles, ld_done 1 cycle later, ld_count=3, fetch address 1 returns 16'hE0F6, address 3 returns 0.
REQ-034 Load 17 words with no ld_last, DEPTH=16 -> the session ends after word 16, ld_ready=0 for word 17, ld_count=16.
REQ-035 DEPTH=12: fetch address 13 -> instr_out=0, addr_err=1; fetch_en during LOAD -> no instr_valid.
REQ-036 Reset pulse after 2 of 5 words -> state IDLE, all words 0, no ld_done; with USER_CODE_CHECKSUM_EN, a load of 16'hFFFF, 16'h0002 -> ld_checksum=16'h0001.
